mixer_hop_ctrl: RTL and testbench



---
 rtl/mixer_hop_pkg.sv | 26 ++
 rtl/mixer_hop_ctrl_table.sv | 30 +++
 rtl/mixer_hop_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mixer_hop_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_hop_pkg.sv
// Shared types for the mixer hop scheduler: FSM states, hop table entry layout and widths.
package mixer_hop_pkg;

    localparam int unsigned HOP_PHASE_W = 32;
    localparam int unsigned HOP_DWELL_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        DWELL,
        DONE
    } hop_state_t;

    typedef struct packed {
        logic [HOP_PHASE_W-1:0] inc;
        logic [HOP_PHASE_W-1:0] offset;
        logic [HOP_DWELL_W-1:0] dwell;
    } hop_entry_t;

    // Dwell counter preload; a programmed 0 still waits for one valid sample.
    function automatic logic [HOP_DWELL_W-1:0] dwell_preload(input logic [HOP_DWELL_W-1:0] dwell);
        return (dwell == '0) ? '0 : dwell - HOP_DWELL_W'(1);
    endfunction

endpackage

// File: rtl/mixer_hop_ctrl_table.sv
// Hop table register file: synchronous write, asynchronous read, synchronous clear.
module hop_table
    import mixer_hop_pkg::*;
#(
    parameter  int unsigned NUM_HOPS = 8,
    localparam int unsigned ADDR_W   = $clog2(NUM_HOPS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  hop_entry_t        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output hop_entry_t        rdata_c
);

    hop_entry_t mem_q [NUM_HOPS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle write and read of one address returns the old entry.
    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/mixer_hop_ctrl.sv
// Frequency-hop scheduler: retunes the mixer DDS per table entry, blanks while the
// mixer pipeline flushes, then counts valid output samples for the entry's dwell.
module mixer_hop_ctrl
    import mixer_hop_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH   = 32,
    parameter int unsigned NUM_HOPS      = 8,
    parameter int unsigned DWELL_WIDTH   = 16,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_we_i,
    input  logic [$clog2(NUM_HOPS)-1:0] cfg_addr_i,
    input  logic [PHASE_WIDTH-1:0]      cfg_inc_i,
    input  logic [PHASE_WIDTH-1:0]      cfg_offset_i,
    input  logic [DWELL_WIDTH-1:0]      cfg_dwell_i,
    input  logic [$clog2(NUM_HOPS)-1:0] last_idx_i,
    input  logic                        loop_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        mix_tvalid_i,
    output logic                        mix_en_o,
    output logic [PHASE_WIDTH-1:0]      phase_inc_o,
    output logic [PHASE_WIDTH-1:0]      phase_offset_o,
    output logic                        blank_o,
    output logic [$clog2(NUM_HOPS)-1:0] hop_idx_o,
    output logic                        hop_strobe_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned IDX_W    = $clog2(NUM_HOPS);
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    hop_state_t             state_q;
    hop_state_t             state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [IDX_W-1:0]       last_q;
    logic                   loop_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q;
    logic [SETTLE_W-1:0]    settle_cnt_q;
    logic                   busy_q;
    logic                   apply_c;
    hop_entry_t             wr_entry_c;
    hop_entry_t             rd_entry_c;

    assign wr_entry_c = '{
        inc:    HOP_PHASE_W'(cfg_inc_i),
        offset: HOP_PHASE_W'(cfg_offset_i),
        dwell:  HOP_DWELL_W'(cfg_dwell_i)
    };

    hop_table #(
        .NUM_HOPS (NUM_HOPS)
    ) u_table (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wdata_i (wr_entry_c),
        .raddr_i (idx_q),
        .rdata_c (rd_entry_c)
    );

    // Next-state and next-index decode; stop overrides every transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: state_d = SETTLE;
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (mix_tvalid_i && (dwell_cnt_q == '0)) begin
                    if (idx_q < last_q) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop_i && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = idx_q;
        end
    end

    assign apply_c = (state_q == LOAD) && (state_d == SETTLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequence configuration, entry index and the settle/dwell counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q        <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            dwell_cnt_q  <= '0;
            settle_cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            if ((state_q == IDLE) && start_i) begin
                last_q <= last_idx_i;
                loop_q <= loop_i;
            end
            case (state_q)
                LOAD: begin
                    dwell_cnt_q  <= DWELL_WIDTH'(dwell_preload(rd_entry_c.dwell));
                    settle_cnt_q <= SETTLE_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
                    end
                end
                DWELL: begin
                    if (mix_tvalid_i && (dwell_cnt_q != '0)) begin
                        dwell_cnt_q <= dwell_cnt_q - DWELL_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags track the state register one-for-one; tuning changes only on LOAD exit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q         <= 1'b0;
            blank_o        <= 1'b1;
            done_o         <= 1'b0;
            hop_strobe_o   <= 1'b0;
            hop_idx_o      <= '0;
            phase_inc_o    <= '0;
            phase_offset_o <= '0;
        end else begin
            busy_q       <= (state_d != IDLE);
            blank_o      <= (state_d != DWELL);
            done_o       <= (state_d == DONE);
            hop_strobe_o <= apply_c;
            if (apply_c) begin
                hop_idx_o      <= idx_q;
                phase_inc_o    <= PHASE_WIDTH'(rd_entry_c.inc);
                phase_offset_o <= PHASE_WIDTH'(rd_entry_c.offset);
            end
        end
    end

    assign mix_en_o = busy_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_mixer_hop_ctrl.sv
// Self-checking bench for mixer_hop_ctrl: table vectors, randomized runs against a
// timeline model, and hand sequences for loop/stop/write/reset corners.
module tb_mixer_hop_ctrl;

    localparam int MAXC = 512;
    localparam int SC   = 8;
    localparam int NH   = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_we_i = 1'b0;
    logic [2:0]  cfg_addr_i = '0;
    logic [31:0] cfg_inc_i = '0;
    logic [31:0] cfg_offset_i = '0;
    logic [15:0] cfg_dwell_i = '0;
    logic [2:0]  last_idx_i = '0;
    logic        loop_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        mix_tvalid_i = 1'b0;
    logic        mix_en_o;
    logic [31:0] phase_inc_o;
    logic [31:0] phase_offset_o;
    logic        blank_o;
    logic [2:0]  hop_idx_o;
    logic        hop_strobe_o;
    logic        busy_o;
    logic        done_o;

    mixer_hop_ctrl #(
        .PHASE_WIDTH   (32),
        .NUM_HOPS      (NH),
        .DWELL_WIDTH   (16),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_inc_i      (cfg_inc_i),
        .cfg_offset_i   (cfg_offset_i),
        .cfg_dwell_i    (cfg_dwell_i),
        .last_idx_i     (last_idx_i),
        .loop_i         (loop_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .mix_tvalid_i   (mix_tvalid_i),
        .mix_en_o       (mix_en_o),
        .phase_inc_o    (phase_inc_o),
        .phase_offset_o (phase_offset_o),
        .blank_o        (blank_o),
        .hop_idx_o      (hop_idx_o),
        .hop_strobe_o   (hop_strobe_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference table contents and the tuning the mixer should currently hold.
    logic [31:0] tab_inc [NH];
    logic [31:0] tab_off [NH];
    logic [15:0] tab_dw  [NH];
    logic [31:0] m_inc;
    logic [31:0] m_off;
    int          m_idx;

    bit          tv       [MAXC];
    logic [31:0] e_inc    [MAXC];
    logic [31:0] e_off    [MAXC];
    int          e_idx    [MAXC];
    bit          e_busy   [MAXC];
    bit          e_blank  [MAXC];
    bit          e_strobe [MAXC];
    bit          e_done   [MAXC];
    int          model_done;
    int          meas_done;
    int          meas_strobe;
    int          meas_unblank;

    typedef struct {
        int last;
        int tv_mode;
        int dwell;
        int exp_done;
        int exp_strobes;
        int exp_unblank;
        int exp_inc;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] inc, input logic [31:0] off, input logic [15:0] dw);
        cfg_we_i     = 1'b1;
        cfg_addr_i   = 3'(a);
        cfg_inc_i    = inc;
        cfg_offset_i = off;
        cfg_dwell_i  = dw;
        tick();
        cfg_we_i     = 1'b0;
        tab_inc[a]   = inc;
        tab_off[a]   = off;
        tab_dw[a]    = dw;
    endtask

    // Timeline model: lays out LOAD, SETTLE and DWELL spans per hop from the valid pattern.
    task automatic model(input int last, input bit lp, input int ncyc);
        int t;
        int pos;
        int need;
        int cnt;
        for (int u = 0; u < ncyc; u++) begin
            e_inc[u] = m_inc;  e_off[u] = m_off;  e_idx[u] = m_idx;
            e_busy[u] = 1'b0;  e_blank[u] = 1'b1; e_strobe[u] = 1'b0; e_done[u] = 1'b0;
        end
        model_done = -1;
        t   = 1;
        pos = 0;
        while (t < ncyc) begin
            e_busy[t] = 1'b1;
            t++;
            m_inc = tab_inc[pos];
            m_off = tab_off[pos];
            m_idx = pos;
            for (int u = t; u < ncyc; u++) begin
                e_inc[u] = m_inc;  e_off[u] = m_off;  e_idx[u] = m_idx;
            end
            if (t < ncyc) e_strobe[t] = 1'b1;
            for (int s = 0; s < SC && t < ncyc; s++) begin
                e_busy[t] = 1'b1;
                t++;
            end
            need = (tab_dw[pos] == 16'd0) ? 1 : int'(tab_dw[pos]);
            cnt  = 0;
            while (cnt < need && t < ncyc) begin
                e_busy[t]  = 1'b1;
                e_blank[t] = 1'b0;
                if (tv[t]) cnt++;
                t++;
            end
            if (cnt < need) break;
            if (pos < last) begin
                pos++;
            end else if (lp) begin
                pos = 0;
            end else begin
                if (t < ncyc) begin
                    e_busy[t] = 1'b1;
                    e_done[t] = 1'b1;
                end
                model_done = t;
                break;
            end
        end
    endtask

    // Start in cycle 0 and compare every cycle against the model timeline.
    task automatic run_seq(input int ncyc, input int last, input bit lp);
        logic [71:0] got;
        logic [71:0] exp;
        meas_done    = -1;
        meas_strobe  = 0;
        meas_unblank = 0;
        last_idx_i   = 3'(last);
        loop_i       = lp;
        for (int t = 0; t < ncyc; t++) begin
            start_i      = (t == 0);
            mix_tvalid_i = tv[t];
            @(negedge clk_i);
            got = {busy_o, mix_en_o, blank_o, hop_strobe_o, done_o, hop_idx_o, phase_inc_o, phase_offset_o};
            exp = {e_busy[t], e_busy[t], e_blank[t], e_strobe[t], e_done[t], 3'(e_idx[t]), e_inc[t], e_off[t]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cycle[%0d] busy/en/blank/strobe/done/idx/inc/off: got %b %b %b %b %b %0d %h %h expected %b %b %b %b %b %0d %h %h",
                         t, got[71], got[70], got[69], got[68], got[67], got[66:64], got[63:32], got[31:0],
                         exp[71], exp[70], exp[69], exp[68], exp[67], exp[66:64], exp[63:32], exp[31:0]);
            end
            if (done_o && meas_done < 0) meas_done = t;
            if (hop_strobe_o) meas_strobe++;
            if (!blank_o) meas_unblank++;
            tick();
        end
        start_i      = 1'b0;
        mix_tvalid_i = 1'b0;
    endtask

    initial begin
        int          scyc [$];
        int          sidx [$];
        logic [31:0] sinc [$];
        int          dcount;
        int          last;
        int          ncyc;
        int          n;

        vecs[0] = '{last: 2, tv_mode: 0, dwell: 4, exp_done: 40, exp_strobes: 3, exp_unblank: 12, exp_inc: 'h300};
        vecs[1] = '{last: 2, tv_mode: 1, dwell: 4, exp_done: 50, exp_strobes: 3, exp_unblank: 22, exp_inc: 'h300};
        vecs[2] = '{last: 2, tv_mode: 0, dwell: 0, exp_done: 31, exp_strobes: 3, exp_unblank: 3,  exp_inc: 'h300};
        vecs[3] = '{last: 0, tv_mode: 0, dwell: 4, exp_done: 14, exp_strobes: 1, exp_unblank: 4,  exp_inc: 'h100};

        for (int a = 0; a < NH; a++) begin
            tab_inc[a] = '0; tab_off[a] = '0; tab_dw[a] = '0;
        end
        m_inc = '0; m_off = '0; m_idx = 0;

        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_mix_en", 64'(mix_en_o), 64'd0);
        check("rst_blank", 64'(blank_o), 64'd1);
        check("rst_strobe", 64'(hop_strobe_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_idx", 64'(hop_idx_o), 64'd0);
        check("rst_inc", 64'(phase_inc_o), 64'd0);
        check("rst_offset", 64'(phase_offset_o), 64'd0);
        tick();

        foreach (vecs[v]) begin
            for (int i = 0; i < 3; i++) begin
                wr(i, 32'h100 * (i + 1), 32'h10 * (i + 1), 16'(vecs[v].dwell));
            end
            for (int t = 0; t < MAXC; t++) begin
                tv[t] = (vecs[v].tv_mode == 0) ? 1'b1 : bit'(t % 2);
            end
            model(vecs[v].last, 1'b0, 60);
            run_seq(60, vecs[v].last, 1'b0);
            check($sformatf("vec%0d_done_cycle", v), 64'(meas_done), 64'(vecs[v].exp_done));
            check($sformatf("vec%0d_strobes", v), 64'(meas_strobe), 64'(vecs[v].exp_strobes));
            check($sformatf("vec%0d_unblanked", v), 64'(meas_unblank), 64'(vecs[v].exp_unblank));
            @(negedge clk_i);
            check($sformatf("vec%0d_final_inc", v), 64'(phase_inc_o), 64'(vecs[v].exp_inc));
            tick();
        end

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NH; a++) begin
                wr(a, $urandom, $urandom, 16'($urandom_range(0, 5)));
            end
            last = $urandom_range(0, NH - 1);
            for (int t = 0; t < MAXC; t++) begin
                tv[t] = (t >= 350) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            model(last, 1'b0, MAXC);
            ncyc = (model_done < 0 || model_done + 3 > MAXC) ? MAXC : model_done + 3;
            run_seq(ncyc, last, 1'b0);
            check($sformatf("rand%0d_done_seen", r), 64'(meas_done), 64'(model_done));
        end

        // Looping pair with a mid-dwell rewrite, a start while busy, and a stop in SETTLE.
        wr(0, 32'h111, 32'h11, 16'd4);
        wr(1, 32'h222, 32'h22, 16'd4);
        last_idx_i = 3'd1;
        loop_i     = 1'b1;
        dcount     = 0;
        for (int t = 0; t <= 68; t++) begin
            start_i      = (t == 0) || (t == 20);
            stop_i       = (t == 67);
            mix_tvalid_i = 1'b1;
            cfg_we_i     = (t == 11);
            cfg_addr_i   = 3'd0;
            cfg_inc_i    = 32'hABC;
            cfg_offset_i = 32'h11;
            cfg_dwell_i  = 16'd4;
            @(negedge clk_i);
            if (hop_strobe_o) begin
                scyc.push_back(t);
                sidx.push_back(int'(hop_idx_o));
                sinc.push_back(phase_inc_o);
            end
            if (done_o) dcount++;
            if (t == 13) check("inc_unchanged_by_live_write", 64'(phase_inc_o), 64'h111);
            if (t == 68) begin
                check("stop_busy", 64'(busy_o), 64'd0);
                check("stop_mix_en", 64'(mix_en_o), 64'd0);
                check("stop_blank", 64'(blank_o), 64'd1);
                check("stop_inc_held", 64'(phase_inc_o), 64'h222);
                check("stop_offset_held", 64'(phase_offset_o), 64'h22);
                check("stop_idx_held", 64'(hop_idx_o), 64'd1);
            end
            tick();
        end
        start_i  = 1'b0;
        stop_i   = 1'b0;
        cfg_we_i = 1'b0;
        tab_inc[0] = 32'hABC;
        check("loop_strobe_count", 64'(scyc.size()), 64'd6);
        check("loop_no_done", 64'(dcount), 64'd0);
        n = (scyc.size() < 6) ? scyc.size() : 6;
        for (int k = 0; k < n; k++) begin
            check($sformatf("loop_strobe_cycle[%0d]", k), 64'(scyc[k]), 64'(2 + 13 * k));
            check($sformatf("loop_strobe_idx[%0d]", k), 64'(sidx[k]), 64'(k % 2));
            check($sformatf("loop_strobe_inc[%0d]", k), 64'(sinc[k]),
                  (k % 2 == 1) ? 64'h222 : ((k == 0) ? 64'h111 : 64'hABC));
        end

        // Reset in the middle of a long dwell clears state and the table.
        wr(0, 32'h333, 32'h33, 16'd10);
        wr(1, 32'h444, 32'h44, 16'd4);
        last_idx_i = 3'd1;
        loop_i     = 1'b0;
        for (int t = 0; t <= 13; t++) begin
            start_i      = (t == 0);
            rst_i        = (t == 12);
            mix_tvalid_i = 1'b1;
            @(negedge clk_i);
            if (t == 12) check("mid_dwell_unblanked", 64'(blank_o), 64'd0);
            if (t == 13) begin
                check("rst2_busy", 64'(busy_o), 64'd0);
                check("rst2_mix_en", 64'(mix_en_o), 64'd0);
                check("rst2_blank", 64'(blank_o), 64'd1);
                check("rst2_done", 64'(done_o), 64'd0);
                check("rst2_inc", 64'(phase_inc_o), 64'd0);
                check("rst2_idx", 64'(hop_idx_o), 64'd0);
            end
            tick();
        end
        rst_i = 1'b0;
        wr(1, 32'h555, 32'h55, 16'd2);
        scyc.delete();
        sinc.delete();
        dcount = -1;
        for (int t = 0; t <= 24; t++) begin
            start_i      = (t == 0) || (t == 5);
            mix_tvalid_i = 1'b1;
            @(negedge clk_i);
            if (hop_strobe_o) begin
                scyc.push_back(t);
                sinc.push_back(phase_inc_o);
            end
            if (done_o && dcount < 0) dcount = t;
            tick();
        end
        start_i = 1'b0;
        check("post_rst_strobe_count", 64'(scyc.size()), 64'd2);
        if (scyc.size() >= 2) begin
            check("post_rst_strobe0_cycle", 64'(scyc[0]), 64'd2);
            check("post_rst_entry0_zeroed", 64'(sinc[0]), 64'd0);
            check("post_rst_strobe1_cycle", 64'(scyc[1]), 64'd12);
            check("post_rst_entry1_inc", 64'(sinc[1]), 64'h555);
        end
        check("post_rst_done_cycle", 64'(dcount), 64'd22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
